scene_spi_loader: RTL and testbench
===================================

Name: scene_spi_loader

Overview:
- FPGA-side upstream feeder for the tiniest-GPU core on the Basys3 board.
- Once per video frame, it streams a scene descriptor (vertex/colour bytes) from a byte ROM into the GPU's SPI input pins.
- Each transfer is triggered by the GPU's own VSync output, so uploads land in vertical blanking.
- Runs in the 50 MHz GPU clock domain, alongside the GPU instance in the board top.

Parameters:
- NBYTES, 36, bytes per frame transfer (1..255).
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1); SCLK = clk/(2*CLK_DIV).
- AW, 8, ROM address width; requires NBYTES ≤ 2^AW.

Ports:
- clk  in  1  50 MHz GPU clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  level; 1 = accept triggers
- vsync_in  in  1  GPU VSync (uo_out[3]), active-low pulse, async to logic until synced
- soft_start  in  1  single-cycle manual trigger
- rom_addr  out  AW  byte address to scene ROM
- rom_data  in  8  ROM byte, valid 1 cycle after rom_addr
- spi_sclk  out  1  SPI clock, mode 0
- spi_mosi  out  1  SPI data, MSB first
- spi_cs_n  out  1  chip select, active-low
- busy  out  1  transfer in progress
- frame_done  out  1  1-cycle pulse at end of transfer
- overrun  out  1  sticky: trigger arrived while busy

Behaviour:
- Reset (async, immediate): spi_cs_n=1, spi_sclk=0, spi_mosi=0, rom_addr=0, busy=0, frame_done=0, overrun=0, FSM=IDLE, sync flops=1.
- vsync_in passes through a 2-FF synchroniser, then an edge register; trig = falling edge (1→0) OR soft_start, gated by enable.
- FSM states: IDLE, FETCH, SHIFT, HOLD.
  - IDLE: rom_addr=0. On trig go to FETCH, busy=1.
  - FETCH: one cycle while rom_data(0) becomes valid.
  - SHIFT entry: cs_n low; shift reg loads rom_data; mosi = bit7; sclk low; rom_addr increments (next byte prefetched).
- SPI timing: each bit is CLK_DIV cycles sclk low, then CLK_DIV cycles high. mosi changes only while sclk is low, at the start of the low phase.
- Bytes are back-to-back with no gap. After bit0's high phase, the next byte's bit7 appears with sclk falling.
- After the last byte's bit0 high phase: HOLD, sclk=0, cs_n low for CLK_DIV cycles. Then cs_n=1, frame_done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - cs_n falls 4 clk edges after the first edge sampling vsync_in low (2 sync + edge reg + FETCH).
  - cs_n falls 2 edges after soft_start is sampled high.
  - cs_n low duration = NBYTES*16*CLK_DIV + CLK_DIV cycles.
- Boundaries:
  - trig while busy: ignored; overrun set, cleared only by reset.
  - vsync edge and soft_start in the same cycle: one transfer.
  - enable dropped mid-transfer: current transfer completes; no new triggers accepted.
  - rom_addr never exceeds NBYTES-1.
  - Reset mid-transfer aborts cleanly: cs_n rises asynchronously with no extra sclk edges.
  - vsync_in held low is not re-triggered; a new high→low transition is required.

Decomposition:
- Shared package gpu_fpga_pkg: FSM state enum, SPI_MODE0 constant, default NBYTES/CLK_DIV.
- One sub-module, spi_tx_shifter: CLK_DIV half-period counter, 3-bit bit counter, 8-bit shift register, load/next_byte handshake.
- Top FSM, synchroniser and ROM addressing remain in scene_spi_loader.

Test Plan:
- Reset mid-SHIFT (assert rst_n=0 at bit 3 of byte 1) -> same-cycle cs_n=1, sclk=0, busy=0; no further sclk edges; next vsync fall gives a full normal transfer.
- NBYTES=3, CLK_DIV=2, ROM={A5,3C,FF}; one vsync low pulse -> cs_n low exactly 98 cycles; exactly 24 sclk rising edges; MOSI sampled on rising edges = 10100101 00111100 11111111; frame_done single pulse as cs_n rises.
- soft_start pulse at cycle 10 -> cs_n low at cycle 12; rom_addr sequence 0,1,2 then back to 0 in IDLE.
- Second vsync falling edge 40 cycles into a 98-cycle transfer -> transfer unaffected, overrun=1 and stays 1, no second transfer.
- enable=0 with vsync pulses -> no cs_n activity; deassert enable mid-transfer -> transfer completes, later vsync ignored.
- vsync_in glitch-free pulse held low 500 cycles -> exactly one transfer; soft_start coincident with vsync edge -> exactly one transfer, overrun=0.

Source files
------------

// File: rtl/gpu_fpga_pkg.sv
// Shared types and defaults for the FPGA-side scene loader that feeds the GPU core over SPI.
package gpu_fpga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // {CPOL, CPHA}: clock idles low, data sampled on the rising edge
    localparam logic [1:0] SPI_MODE0 = 2'b00;

    localparam int unsigned DEF_NBYTES  = 36;
    localparam int unsigned DEF_CLK_DIV = 4;
    localparam int unsigned DEF_AW      = 8;

endpackage

// File: rtl/scene_spi_loader_if.sv
// Scene ROM port plus SPI pins between the loader (master) and the GPU/ROM side (slave).
interface scene_spi_loader_if
    import gpu_fpga_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
);
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_cs_n;

    modport master (
        output rom_addr, spi_sclk, spi_mosi, spi_cs_n,
        input  rom_data
    );

    modport slave (
        input  rom_addr, spi_sclk, spi_mosi, spi_cs_n,
        output rom_data
    );
endinterface

// File: rtl/spi_tx_shifter.sv
// Mode-0 byte serialiser: CLK_DIV cycles low then CLK_DIV cycles high per bit, MSB first.
module spi_tx_shifter
    import gpu_fpga_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       sclk,
    output logic       mosi,
    output logic       byte_end_c
);
    localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sreg;
    logic          phase_end;

    assign phase_end  = active && (div_cnt == DIV_LAST);
    // Last cycle of bit0's high phase: the owner may load the next byte here for a gapless stream
    assign byte_end_c = phase_end && sclk && (bit_cnt == 3'd0);
    assign mosi       = sreg[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            sclk    <= SPI_MODE0[1];
        end else if (load) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= 3'd7;
            sreg    <= data;
            sclk    <= SPI_MODE0[1];
        end else if (byte_end_c) begin
            active  <= 1'b0;
            div_cnt <= '0;
            sreg    <= '0;
            sclk    <= SPI_MODE0[1];
        end else if (phase_end) begin
            div_cnt <= '0;
            if (!sclk) begin
                sclk <= 1'b1;
            end else begin
                sclk    <= 1'b0;
                bit_cnt <= bit_cnt - 3'd1;
                sreg    <= {sreg[6:0], 1'b0};
            end
        end else if (active) begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/scene_spi_loader.sv
// Streams NBYTES of scene ROM into the GPU's SPI pins once per VSync fall (or soft_start).
module scene_spi_loader
    import gpu_fpga_pkg::*;
#(
    parameter int unsigned NBYTES  = DEF_NBYTES,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned AW      = DEF_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                vsync_in,
    input  logic                soft_start,
    scene_spi_loader_if.master  bus,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);
    localparam int unsigned   HW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(CLK_DIV - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NBYTES - 1);
    localparam logic [7:0]    BYTE_LAST = 8'(NBYTES - 1);

    logic          vs_s1, vs_s2, vs_d;
    logic          trig_c;
    state_t        state, state_d;
    logic [AW-1:0] addr, addr_d;
    logic [7:0]    byte_idx, byte_idx_d;
    logic [HW-1:0] hold_cnt, hold_cnt_d;
    logic          cs_n, cs_n_d;
    logic          busy_d, done_d, overrun_d;
    logic          load_c, byte_end_c;

    // VSync synchroniser plus edge register; idles high so reset never looks like a fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            vs_d  <= 1'b1;
        end else begin
            vs_s1 <= vsync_in;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
        end
    end

    assign trig_c = enable && ((vs_d && !vs_s2) || soft_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            byte_idx   <= '0;
            hold_cnt   <= '0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            addr       <= addr_d;
            byte_idx   <= byte_idx_d;
            hold_cnt   <= hold_cnt_d;
            cs_n       <= cs_n_d;
            busy       <= busy_d;
            frame_done <= done_d;
            overrun    <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state;
        addr_d     = addr;
        byte_idx_d = byte_idx;
        hold_cnt_d = hold_cnt;
        cs_n_d     = cs_n;
        busy_d     = busy;
        done_d     = 1'b0;
        load_c     = 1'b0;
        overrun_d  = overrun || (trig_c && (state != IDLE));

        case (state)
            IDLE: begin
                addr_d = '0;
                if (trig_c) begin
                    state_d = FETCH;
                    busy_d  = 1'b1;
                end
            end
            FETCH: begin
                state_d    = SHIFT;
                load_c     = 1'b1;
                cs_n_d     = 1'b0;
                byte_idx_d = '0;
                if (addr != ADDR_LAST) addr_d = addr + AW'(1);
            end
            SHIFT: begin
                // Address runs one byte ahead of the shifter and saturates at the last byte
                if (byte_end_c) begin
                    if (byte_idx != BYTE_LAST) begin
                        load_c     = 1'b1;
                        byte_idx_d = byte_idx + 8'd1;
                        if (addr != ADDR_LAST) addr_d = addr + AW'(1);
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    addr_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    spi_tx_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_c),
        .data       (bus.rom_data),
        .sclk       (bus.spi_sclk),
        .mosi       (bus.spi_mosi),
        .byte_end_c (byte_end_c)
    );

    assign bus.rom_addr = addr;
    assign bus.spi_cs_n = cs_n;

endmodule

// File: tb/tb_scene_spi_loader.sv
// Self-checking bench for scene_spi_loader: vector table, latency/corner sequences, random frames.
module tb_scene_spi_loader;
    localparam int unsigned NB = 3;
    localparam int unsigned CD = 2;
    localparam int unsigned AW = 8;
    localparam int XFER_LOW = NB * 16 * CD + CD;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic vsync_in = 1'b1;
    logic soft_start = 1'b0;
    logic busy, frame_done, overrun;
    logic [7:0] rom [256];

    scene_spi_loader_if #(.AW(AW)) bus ();

    scene_spi_loader #(.NBYTES(NB), .CLK_DIV(CD), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .vsync_in   (vsync_in),
        .soft_start (soft_start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // Passive monitor, sampled on the falling edge
    int m_low = 0, m_rise = 0, m_xfer = 0, m_done = 0, m_bad = 0, m_over = 0;
    logic bitq[$];
    logic p_cs = 1'b1, p_sclk = 1'b0;
    always @(negedge clk) begin
        if (bus.spi_cs_n === 1'b0) m_low++;
        if (p_cs === 1'b1 && bus.spi_cs_n === 1'b0) m_xfer++;
        if (bus.spi_sclk === 1'b1 && p_sclk === 1'b0) begin
            m_rise++;
            bitq.push_back(bus.spi_mosi);
            if (bus.spi_cs_n !== 1'b0) m_bad++;
        end
        if (frame_done === 1'b1) begin
            m_done++;
            if (bus.spi_cs_n !== 1'b1 || p_cs !== 1'b0) m_bad++;
        end
        if (rst_n && p_cs === 1'b0 && bus.spi_cs_n === 1'b1 && frame_done !== 1'b1) m_bad++;
        if (bus.rom_addr > AW'(NB - 1)) m_over++;
        p_cs   = bus.spi_cs_n;
        p_sclk = bus.spi_sclk;
    end

    int b_low, b_rise, b_xfer, b_done, b_bad, b_over, b_bits;
    int n_tests = 0, n_fail = 0;

    task automatic snap();
        b_low = m_low; b_rise = m_rise; b_xfer = m_xfer; b_done = m_done;
        b_bad = m_bad; b_over = m_over; b_bits = bitq.size();
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int bits_since(input int start);
        int v = 0;
        for (int i = start; i < bitq.size(); i++) v = (v << 1) | ((bitq[i] === 1'b1) ? 1 : 0);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vsync_in = 1'b1; soft_start = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic pulse_vsync(input int len);
        vsync_in = 1'b0;
        tick(len);
        vsync_in = 1'b1;
    endtask

    // kind 0: vsync fall, 1: soft_start, 2: soft_start in the same cycle the vsync fall is seen
    task automatic trigger(input int kind);
        case (kind)
            0: pulse_vsync(3);
            1: begin soft_start = 1'b1; tick(1); soft_start = 1'b0; end
            default: begin
                vsync_in = 1'b0; tick(2);
                soft_start = 1'b1; tick(1);
                soft_start = 1'b0; tick(1);
                vsync_in = 1'b1;
            end
        endcase
    endtask

    task automatic wait_cs_low(input string name);
        int k = 0;
        while (bus.spi_cs_n !== 1'b0 && k < 20) begin tick(1); k++; end
        check(name, int'(bus.spi_cs_n === 1'b0), 1);
    endtask

    task automatic set_rom(input logic [23:0] d);
        rom[0] = d[23:16]; rom[1] = d[15:8]; rom[2] = d[7:0];
    endtask

    typedef struct {
        int          kind;
        logic        en;
        logic [23:0] data;
        int          exp_xfer;
        int          exp_low;
        int          exp_rise;
        logic [23:0] exp_bits;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        for (int i = 0; i < 256; i++) rom[i] = 8'hEE;

        vecs[0] = '{0, 1'b1, 24'hA53CFF, 1, 98, 24, 24'hA53CFF, 1'b0};
        vecs[1] = '{1, 1'b1, 24'h00FF81, 1, 98, 24, 24'h00FF81, 1'b0};
        vecs[2] = '{2, 1'b1, 24'h5AC301, 1, 98, 24, 24'h5AC301, 1'b0};
        vecs[3] = '{0, 1'b0, 24'h123456, 0, 0, 0, 24'h000000, 1'b0};
        vecs[4] = '{1, 1'b0, 24'h123456, 0, 0, 0, 24'h000000, 1'b0};
        vecs[5] = '{2, 1'b0, 24'h123456, 0, 0, 0, 24'h000000, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_cs_n", int'(bus.spi_cs_n), 1);
        check("rst_sclk", int'(bus.spi_sclk), 0);
        check("rst_mosi", int'(bus.spi_mosi), 0);
        check("rst_addr", int'(bus.rom_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_ovr",  int'(overrun), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            do_reset();
            set_rom(vecs[i].data);
            enable = vecs[i].en;
            snap();
            trigger(vecs[i].kind);
            tick(150);
            check($sformatf("v%0d_xfer", i), m_xfer - b_xfer, vecs[i].exp_xfer);
            check($sformatf("v%0d_low", i),  m_low - b_low,   vecs[i].exp_low);
            check($sformatf("v%0d_rise", i), m_rise - b_rise, vecs[i].exp_rise);
            check($sformatf("v%0d_bits", i), bits_since(b_bits), int'(vecs[i].exp_bits));
            check($sformatf("v%0d_done", i), m_done - b_done, vecs[i].exp_xfer);
            check($sformatf("v%0d_ovr", i),  int'(overrun), int'(vecs[i].exp_ovr));
            check($sformatf("v%0d_proto", i), (m_bad - b_bad) + (m_over - b_over), 0);
        end
        enable = 1'b1;

        // soft_start latency and ROM address walk
        do_reset();
        set_rom(24'hA53CFF);
        snap();
        soft_start = 1'b1;
        tick(1);
        soft_start = 1'b0;
        check("soft_fetch_cs", int'(bus.spi_cs_n), 1);
        check("soft_fetch_addr", int'(bus.rom_addr), 0);
        tick(1);
        check("soft_cs_low", int'(bus.spi_cs_n), 0);
        check("soft_addr1", int'(bus.rom_addr), 1);
        tick(40);
        check("soft_addr2", int'(bus.rom_addr), 2);
        tick(100);
        check("soft_addr_idle", int'(bus.rom_addr), 0);
        check("soft_busy_idle", int'(busy), 0);
        check("soft_addr_range", m_over - b_over, 0);

        // vsync latency: three edges after the first low sample still high, low after the fourth
        do_reset();
        snap();
        vsync_in = 1'b0;
        tick(3);
        check("vs_lat_cs3", int'(bus.spi_cs_n), 1);
        check("vs_lat_busy3", int'(busy), 1);
        tick(1);
        check("vs_lat_cs4", int'(bus.spi_cs_n), 0);
        tick(2);
        vsync_in = 1'b1;
        tick(150);
        check("vs_lat_xfer", m_xfer - b_xfer, 1);

        // Second vsync fall during a transfer
        do_reset();
        snap();
        pulse_vsync(3);
        wait_cs_low("ovr_start");
        tick(40);
        pulse_vsync(3);
        tick(5);
        check("ovr_set", int'(overrun), 1);
        tick(150);
        check("ovr_xfer", m_xfer - b_xfer, 1);
        check("ovr_low", m_low - b_low, XFER_LOW);
        check("ovr_rise", m_rise - b_rise, 24);
        check("ovr_sticky", int'(overrun), 1);

        // enable dropped mid-transfer
        do_reset();
        snap();
        pulse_vsync(3);
        wait_cs_low("en_start");
        tick(20);
        enable = 1'b0;
        tick(130);
        check("en_low", m_low - b_low, XFER_LOW);
        check("en_rise", m_rise - b_rise, 24);
        snap();
        pulse_vsync(3);
        tick(150);
        check("en_ignored", m_xfer - b_xfer, 0);
        check("en_ovr", int'(overrun), 0);
        enable = 1'b1;

        // vsync held low for a long time
        do_reset();
        snap();
        vsync_in = 1'b0;
        tick(500);
        vsync_in = 1'b1;
        tick(150);
        check("hold_xfer", m_xfer - b_xfer, 1);
        check("hold_low", m_low - b_low, XFER_LOW);
        check("hold_ovr", int'(overrun), 0);

        // Reset during bit 3 of byte 1
        do_reset();
        set_rom(24'h3CA55A);
        snap();
        pulse_vsync(3);
        for (int k = 0; k < 300 && (m_rise - b_rise) < 12; k++) tick(1);
        check("mrst_reached", int'((m_rise - b_rise) >= 12), 1);
        tick(CD);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_cs_n", int'(bus.spi_cs_n), 1);
        check("mrst_sclk", int'(bus.spi_sclk), 0);
        check("mrst_busy", int'(busy), 0);
        snap();
        tick(10);
        rst_n = 1'b1;
        tick(50);
        check("mrst_no_edges", m_rise - b_rise, 0);
        snap();
        pulse_vsync(3);
        tick(150);
        check("mrst_next_low", m_low - b_low, XFER_LOW);
        check("mrst_next_rise", m_rise - b_rise, 24);
        check("mrst_next_bits", bits_since(b_bits), int'(24'h3CA55A));

        // Randomized frames against a byte-level model
        do_reset();
        for (int it = 0; it < 10; it++) begin
            logic [7:0] bytes [NB];
            logic       en;
            int         kind, exp_bits, exp_low, exp_xfer;
            for (int b = 0; b < NB; b++) begin
                bytes[b] = 8'($urandom);
                rom[b]   = bytes[b];
            end
            en   = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 2);
            exp_bits = 0;
            for (int b = 0; b < NB; b++) exp_bits = (exp_bits << 8) | int'(bytes[b]);
            exp_xfer = en ? 1 : 0;
            exp_low  = en ? XFER_LOW : 0;
            if (!en) exp_bits = 0;
            enable = en;
            tick($urandom_range(1, 20));
            snap();
            trigger(kind);
            tick(150);
            check($sformatf("r%0d_xfer", it), m_xfer - b_xfer, exp_xfer);
            check($sformatf("r%0d_low", it),  m_low - b_low, exp_low);
            check($sformatf("r%0d_bits", it), bits_since(b_bits), exp_bits);
            check($sformatf("r%0d_done", it), m_done - b_done, exp_xfer);
            check($sformatf("r%0d_proto", it), (m_bad - b_bad) + (m_over - b_over), 0);
        end
        check("rand_ovr", int'(overrun), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
